// File: rtl/int_to_float_encoder_pkg.sv
// Shared floating-point definitions for the int_to_float_encoder slice.
// Package fp_pkg: field layout of the 32-bit float word (sign, 6-bit
// exponent with bias 31, 25-bit fraction with hidden one), the status codes
// used by the floating-point adder, and the encoder state encoding.
package fp_pkg;

  localparam int WORD_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 6;
  localparam int FRAC_W   = 25;
  localparam int DISC_W   = WORD_W - 1 - FRAC_W;
  localparam int EXP_BIAS = 31;

  // Biased exponent of a normalised magnitude before the shift count and the
  // fixed-point scaling are subtracted: bias plus the leading-one position.
  localparam int EXP_NORM_BASE = EXP_BIAS + SIGN_BIT;

  localparam logic [3:0] STATUS_EXACT     = 4'd0;
  localparam logic [3:0] STATUS_OVERFLOW  = 4'd1;
  localparam logic [3:0] STATUS_UNDERFLOW = 4'd2;
  localparam logic [3:0] STATUS_INEXACT   = 4'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NORMALIZE = 3'd1,
    PACK      = 3'd2
  } state_e;

endpackage

// File: rtl/int_to_float_encoder_if.sv
// Handshake and data bus of the integer-to-float encoder.
// The master drives start_in/data_in; the encoder (slave) returns the
// busy/done handshake, the packed float, its status and the state code.
interface int_to_float_encoder_if;
  import fp_pkg::*;

  logic              start_in;
  logic [WORD_W-1:0] data_in;
  logic              busy_out;
  logic              done_out;
  logic [WORD_W-1:0] data_out;
  logic [3:0]        status_out;
  logic [2:0]        qual_lugar;

  modport master (
    output start_in, data_in,
    input  busy_out, done_out, data_out, status_out, qual_lugar
  );

  modport slave (
    input  start_in, data_in,
    output busy_out, done_out, data_out, status_out, qual_lugar
  );

endinterface

// File: rtl/int_to_float_encoder_pack.sv
// fp_pack: combinational packer for the integer-to-float encoder.
// Turns the normalised magnitude and shift count into the float word and a
// status code (zero, underflow, overflow, inexact, exact in that priority).
// Optional macro ROUND_NEAREST_EN adds round-to-nearest (ties away from zero
// on the magnitude); without it the discarded bits are simply truncated.
module fp_pack
  import fp_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic                      sign_i,
  input  logic [5:0]                k_i,
  input  logic [FRAC_W+DISC_W-1:0]  normMag_i,
  input  logic                      zero_i,
  output logic [WORD_W-1:0]         data_o,
  output logic [3:0]                status_o
);

  logic signed [7:0]   expBase;
  logic signed [7:0]   expUse;
  logic [FRAC_W-1:0]   fracRaw;
  logic [FRAC_W-1:0]   fracUse;
  logic [DISC_W-1:0]   discarded;

  assign fracRaw   = normMag_i[FRAC_W+DISC_W-1:DISC_W];
  assign discarded = normMag_i[DISC_W-1:0];
  assign expBase   = 8'(EXP_NORM_BASE) - {2'b00, k_i} - 8'(FRAC_BITS);

`ifdef ROUND_NEAREST_EN
  logic [FRAC_W:0] fracSum;

  // The top discarded bit is the half-LSB; a carry out of an all-ones
  // fraction wraps it to zero and bumps the exponent.
  assign fracSum = {1'b0, fracRaw} + {{FRAC_W{1'b0}}, discarded[DISC_W-1]};
  assign fracUse = fracSum[FRAC_W-1:0];
  assign expUse  = expBase + $signed({7'b0000000, fracSum[FRAC_W]});
`else
  assign fracUse = fracRaw;
  assign expUse  = expBase;
`endif

  // Status priority: zero, then exponent range, then lost bits.
  always_comb begin
    data_o   = '0;
    status_o = STATUS_EXACT;
    if (zero_i) begin
      data_o   = '0;
      status_o = STATUS_EXACT;
    end else if (expUse <= 8'sd0) begin
      data_o   = {sign_i, {(WORD_W-1){1'b0}}};
      status_o = STATUS_UNDERFLOW;
    end else if (expUse >= 8'sd63) begin
      data_o   = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      status_o = STATUS_OVERFLOW;
    end else begin
      data_o   = {sign_i, expUse[EXP_W-1:0], fracUse};
      status_o = (discarded != '0) ? STATUS_INEXACT : STATUS_EXACT;
    end
  end

endmodule

// File: rtl/int_to_float_encoder.sv
// int_to_float_encoder: converts a signed 32-bit fixed-point value with
// FRAC_BITS fractional bits into the 32-bit float format used by the adder.
// Normalisation shifts the magnitude one bit per clock until the leading one
// reaches bit 31, then fp_pack builds the word and status. Rounding is
// selected by the ROUND_NEAREST_EN macro inside fp_pack.
module int_to_float_encoder
  import fp_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input logic                    clock_100kHz,
  input logic                    reset,
  int_to_float_encoder_if.slave  bus
);

  state_e            state_q;
  logic              sign_q;
  logic              zero_q;
  logic [WORD_W-1:0] mag_q;
  logic [5:0]        k_q;
  logic [WORD_W-1:0] data_q;
  logic [3:0]        status_q;
  logic              done_q;

  logic [WORD_W-1:0] magIn;
  logic [WORD_W-1:0] data_d;
  logic [3:0]        status_d;

  assign magIn = bus.data_in[SIGN_BIT] ? (~bus.data_in + 32'd1) : bus.data_in;

  fp_pack #(
    .FRAC_BITS (FRAC_BITS)
  ) packer (
    .sign_i    (sign_q),
    .k_i       (k_q),
    .normMag_i (mag_q[WORD_W-2:0]),
    .zero_i    (zero_q),
    .data_o    (data_d),
    .status_o  (status_d)
  );

  // Control FSM: capture in IDLE, shift in NORMALIZE, register result in PACK.
  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      mag_q    <= '0;
      k_q      <= '0;
      data_q   <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            sign_q  <= bus.data_in[SIGN_BIT];
            mag_q   <= magIn;
            k_q     <= '0;
            zero_q  <= (magIn == '0);
            state_q <= (magIn == '0) ? PACK : NORMALIZE;
          end
        end
        NORMALIZE: begin
          if (mag_q[WORD_W-1]) begin
            state_q <= PACK;
          end else begin
            mag_q <= {mag_q[WORD_W-2:0], 1'b0};
            k_q   <= k_q + 6'd1;
          end
        end
        PACK: begin
          data_q   <= data_d;
          status_q <= status_d;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_out   = (state_q != IDLE);
  assign bus.done_out   = done_q;
  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;
  assign bus.qual_lugar = state_q;

endmodule

// File: tb/tb_int_to_float_encoder.sv
// Testbench for int_to_float_encoder: two instances (FRAC_BITS 0 and 31),
// directed corner cases followed by random operands, all compared against a
// value-level reference model of the float encoding.
module tb_int_to_float_encoder;

  logic clock_100kHz = 1'b0;
  logic reset;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clock_100kHz = ~clock_100kHz;

  int_to_float_encoder_if bus0 ();
  int_to_float_encoder_if bus31 ();

  int_to_float_encoder #(.FRAC_BITS(0)) dut (
    .clock_100kHz (clock_100kHz),
    .reset        (reset),
    .bus          (bus0)
  );

  int_to_float_encoder #(.FRAC_BITS(31)) dutWide (
    .clock_100kHz (clock_100kHz),
    .reset        (reset),
    .bus          (bus31)
  );

  // Reference: value = mag * 2^-fracBits, exponent from the leading-one
  // position, fraction from the remainder below it scaled to 25 bits.
  function automatic void refModel(input logic [31:0] value, input int fracBits,
                                   output logic [31:0] word, output logic [3:0] status,
                                   output int latency);
    longint sv;
    longint mag;
    longint rem;
    longint frac;
    longint lost;
    int     p;
    int     e;
    logic   sign;
    sign = value[31];
    sv   = longint'($signed(value));
    mag  = (sv < 0) ? -sv : sv;
    if (mag == 0) begin
      word    = 32'd0;
      status  = 4'd0;
      latency = 1;
      return;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    latency = (31 - p) + 2;
    e   = 31 + p - fracBits;
    rem = mag - (longint'(1) << p);
    if (p > 25) begin
      frac = rem >> (p - 25);
      lost = rem & ((longint'(1) << (p - 25)) - 1);
    end else begin
      frac = rem << (25 - p);
      lost = 0;
    end
`ifdef ROUND_NEAREST_EN
    if (p > 25 && ((rem >> (p - 26)) & 1) == 1) begin
      frac++;
      if (frac == (longint'(1) << 25)) begin
        frac = 0;
        e++;
      end
    end
`endif
    if (e <= 0) begin
      word   = {sign, 31'd0};
      status = 4'd2;
    end else if (e >= 63) begin
      word   = {sign, 6'h3F, 25'd0};
      status = 4'd1;
    end else begin
      word   = {sign, 6'(e), 25'(frac)};
      status = (lost != 0) ? 4'd3 : 4'd0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents an operand for one edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic [31:0] value, input bit wide);
    if (wide) begin
      bus31.start_in = 1'b1;
      bus31.data_in  = value;
    end else begin
      bus0.start_in = 1'b1;
      bus0.data_in  = value;
    end
    @(posedge clock_100kHz);
    #1;
    bus0.start_in  = 1'b0;
    bus31.start_in = 1'b0;
  endtask

  // Counts edges until done_out; latency stays -1 if the bound expires.
  task automatic waitDone(input bit wide, input int limit, output int latency,
                          output logic [31:0] word, output logic [3:0] status);
    latency = -1;
    word    = 32'd0;
    status  = 4'd0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clock_100kHz);
      #1;
      if ((wide ? bus31.done_out : bus0.done_out) === 1'b1) begin
        latency = n;
        word    = wide ? bus31.data_out : bus0.data_out;
        status  = wide ? bus31.status_out : bus0.status_out;
        break;
      end
    end
  endtask

  task automatic convertAndCheck(input string tag, input logic [31:0] value, input bit wide);
    logic [31:0] expWord;
    logic [31:0] gotWord;
    logic [3:0]  expStatus;
    logic [3:0]  gotStatus;
    int          expLat;
    int          gotLat;
    refModel(value, wide ? 31 : 0, expWord, expStatus, expLat);
    @(negedge clock_100kHz);
    applyStimulus(value, wide);
    checkOutput({tag, " qual"}, 32'(wide ? bus31.qual_lugar : bus0.qual_lugar),
                (value == 32'd0) ? 32'd2 : 32'd1);
    waitDone(wide, 40, gotLat, gotWord, gotStatus);
    checkOutput({tag, " latency"}, 32'(gotLat), 32'(expLat));
    checkOutput({tag, " data"}, gotWord, expWord);
    checkOutput({tag, " status"}, 32'(gotStatus), 32'(expStatus));
    checkOutput({tag, " busyAtDone"}, 32'(wide ? bus31.busy_out : bus0.busy_out), 32'd0);
    @(posedge clock_100kHz);
    #1;
    checkOutput({tag, " donePulse"}, 32'(wide ? bus31.done_out : bus0.done_out), 32'd0);
    checkOutput({tag, " dataHeld"}, wide ? bus31.data_out : bus0.data_out, expWord);
  endtask

  initial begin
    logic [31:0] expWord;
    logic [31:0] gotWord;
    logic [3:0]  expStatus;
    logic [3:0]  gotStatus;
    logic [31:0] v;
    int          expLat;
    int          gotLat;
    int          doneSeen;

    reset          = 1'b1;
    bus0.start_in  = 1'b0;
    bus0.data_in   = 32'd0;
    bus31.start_in = 1'b0;
    bus31.data_in  = 32'd0;
    repeat (2) @(posedge clock_100kHz);
    #1;
    checkOutput("reset data", bus0.data_out, 32'd0);
    checkOutput("reset status", 32'(bus0.status_out), 32'd0);
    checkOutput("reset done", 32'(bus0.done_out), 32'd0);
    checkOutput("reset busy", 32'(bus0.busy_out), 32'd0);
    checkOutput("reset qual", 32'(bus0.qual_lugar), 32'd0);
    @(negedge clock_100kHz);
    reset = 1'b0;

    // Directed corner cases
    convertAndCheck("one", 32'h0000_0001, 1'b0);
    convertAndCheck("minusSix", 32'hFFFF_FFFA, 1'b0);
    convertAndCheck("minInt", 32'h8000_0000, 1'b0);
    convertAndCheck("maxInt", 32'h7FFF_FFFF, 1'b0);
    convertAndCheck("zero", 32'h0000_0000, 1'b0);
    convertAndCheck("wideOne", 32'h0000_0001, 1'b1);
    convertAndCheck("wideMax", 32'h7FFF_FFFF, 1'b1);

    // start_in pulsed mid-NORMALIZE must not disturb the running conversion
    refModel(32'h0000_0001, 0, expWord, expStatus, expLat);
    @(negedge clock_100kHz);
    applyStimulus(32'h0000_0001, 1'b0);
    repeat (4) @(posedge clock_100kHz);
    @(negedge clock_100kHz);
    bus0.start_in = 1'b1;
    bus0.data_in  = 32'h8000_0000;
    @(posedge clock_100kHz);
    #1;
    bus0.start_in = 1'b0;
    checkOutput("midPulse busy", 32'(bus0.busy_out), 32'd1);
    waitDone(1'b0, 40, gotLat, gotWord, gotStatus);
    checkOutput("midPulse latency", 32'(gotLat + 5), 32'(expLat));
    checkOutput("midPulse data", gotWord, expWord);
    checkOutput("midPulse status", 32'(gotStatus), 32'(expStatus));

    // Back-to-back: start asserted during the done cycle is accepted at once
    @(negedge clock_100kHz);
    applyStimulus(32'h8000_0000, 1'b0);
    waitDone(1'b0, 40, gotLat, gotWord, gotStatus);
    checkOutput("b2bFirst latency", 32'(gotLat), 32'd2);
    checkOutput("b2bFirst data", gotWord, 32'hFC00_0000);
    refModel(32'hFFFF_FFFA, 0, expWord, expStatus, expLat);
    applyStimulus(32'hFFFF_FFFA, 1'b0);
    checkOutput("b2bSecond qual", 32'(bus0.qual_lugar), 32'd1);
    waitDone(1'b0, 40, gotLat, gotWord, gotStatus);
    checkOutput("b2bSecond latency", 32'(gotLat), 32'(expLat));
    checkOutput("b2bSecond data", gotWord, expWord);
    checkOutput("b2bSecond status", 32'(gotStatus), 32'(expStatus));

    // Reset during NORMALIZE aborts: outputs clear, no done afterwards
    @(negedge clock_100kHz);
    applyStimulus(32'h0000_0001, 1'b0);
    repeat (3) @(posedge clock_100kHz);
    @(negedge clock_100kHz);
    reset = 1'b1;
    #1;
    checkOutput("abort data", bus0.data_out, 32'd0);
    checkOutput("abort status", 32'(bus0.status_out), 32'd0);
    checkOutput("abort done", 32'(bus0.done_out), 32'd0);
    checkOutput("abort busy", 32'(bus0.busy_out), 32'd0);
    checkOutput("abort qual", 32'(bus0.qual_lugar), 32'd0);
    @(negedge clock_100kHz);
    reset    = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clock_100kHz);
      #1;
      if (bus0.done_out === 1'b1) doneSeen++;
    end
    checkOutput("abort noDone", 32'(doneSeen), 32'd0);
    convertAndCheck("afterAbort", 32'hFFFF_FFFA, 1'b0);

    // Random operands over the whole range of leading-one positions
    for (int i = 0; i < 24; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      convertAndCheck($sformatf("rand%0d", i), v, (i % 4) == 3);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
